// File: rtl/score_counter_pkg.sv
// Shared scoreboard types and constants: BCD digit width, digit/score limits,
// default debounce length, and the BCD saturating-increment helper.
package score_counter_pkg;

    localparam int unsigned DIGIT_W         = 4;
    localparam int unsigned DIGIT_MAX       = 9;
    localparam int unsigned SCORE_MAX       = 99;
    localparam int unsigned DEBOUNCE_MS_DEF = 20;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd_score_t;

    function automatic logic bcd_at_max(input bcd_score_t s);
        return (s.tens == bcd_digit_t'(SCORE_MAX / 10)) &&
               (s.ones == bcd_digit_t'(SCORE_MAX % 10));
    endfunction

    // Saturates at SCORE_MAX; the >= guard keeps a digit from ever leaving 0..9.
    function automatic bcd_score_t bcd_inc_sat(input bcd_score_t s);
        bcd_score_t r;
        r = s;
        if (!bcd_at_max(s)) begin
            if (s.ones >= bcd_digit_t'(DIGIT_MAX)) begin
                r.ones = '0;
                r.tens = s.tens + bcd_digit_t'(1);
            end else begin
                r.ones = s.ones + bcd_digit_t'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/score_counter_btn_debounce.sv
// One raw button: 2-flop synchroniser, stability debouncer, registered press pulse.
// press_o rises DEBOUNCE_MS+1 edges after the first edge sampling a stable high input.
module btn_debounce
    import score_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
    input  logic clk_1khz,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_MS - 1);

    logic       sync1_q, sync2_q;
    logic       acc_q, acc_d;
    logic       press_q, press_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        if (sync2_q != acc_q) begin
            if (cnt_q == CNT_LAST) begin
                acc_d = ~acc_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
        // Only the 0->1 transition of the accepted level is a press.
        press_d = acc_d & ~acc_q;
    end

    always_ff @(posedge clk_1khz or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/score_counter.sv
// Two-player BCD scoreboard (0..99 each, saturating) with debounced score and clear buttons.
// Digits and score_evt_o update one edge after a debounced press pulse; clear wins over scores.
module score_counter
    import score_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
    input  logic               clk_1khz,
    input  logic               rst_i,
    input  logic               p1_btn_i,
    input  logic               p2_btn_i,
    input  logic               clr_btn_i,
    output logic [DIGIT_W-1:0] p1_tens_o,
    output logic [DIGIT_W-1:0] p1_ones_o,
    output logic [DIGIT_W-1:0] p2_tens_o,
    output logic [DIGIT_W-1:0] p2_ones_o,
    output logic               score_evt_o
);

    logic p1_press, p2_press, clr_press;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_p1_btn (
        .clk_1khz (clk_1khz),
        .rst_i    (rst_i),
        .btn_i    (p1_btn_i),
        .press_o  (p1_press)
    );

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_p2_btn (
        .clk_1khz (clk_1khz),
        .rst_i    (rst_i),
        .btn_i    (p2_btn_i),
        .press_o  (p2_press)
    );

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_clr_btn (
        .clk_1khz (clk_1khz),
        .rst_i    (rst_i),
        .btn_i    (clr_btn_i),
        .press_o  (clr_press)
    );

    bcd_score_t p1_q, p1_d;
    bcd_score_t p2_q, p2_d;
    logic       evt_q, evt_d;

    always_comb begin
        p1_d  = p1_q;
        p2_d  = p2_q;
        evt_d = 1'b0;
        if (clr_press) begin
            // A clear always signals, even when the board is already 00:00.
            p1_d  = '0;
            p2_d  = '0;
            evt_d = 1'b1;
        end else begin
            if (p1_press) p1_d = bcd_inc_sat(p1_q);
            if (p2_press) p2_d = bcd_inc_sat(p2_q);
            evt_d = (p1_d != p1_q) || (p2_d != p2_q);
        end
    end

    always_ff @(posedge clk_1khz or posedge rst_i) begin
        if (rst_i) begin
            p1_q  <= '0;
            p2_q  <= '0;
            evt_q <= 1'b0;
        end else begin
            p1_q  <= p1_d;
            p2_q  <= p2_d;
            evt_q <= evt_d;
        end
    end

    assign p1_tens_o   = p1_q.tens;
    assign p1_ones_o   = p1_q.ones;
    assign p2_tens_o   = p2_q.tens;
    assign p2_ones_o   = p2_q.ones;
    assign score_evt_o = evt_q;

endmodule
